weight_stream_loader: RTL and testbench
=======================================

Name: weight_stream_loader

Overview:
- Consumer end of the coefficient stream that the per-layer weight sources produce (FIFO-style din/full_n/write).
- Pops KERN_SIZE coefficients from an ap_fifo read interface (dout/empty_n/read) into a local register bank.
- Once loaded, serves them to the convolution datapath through a registered random-access read port.
- Reload on demand lets one instance refill between kernels.

Parameters:
- COEFF_WIDTH, 16, bit width of one coefficient; matches the codebase coeff_width.
- KERN_SIZE, 9, number of coefficients per load; must be ≥ 2.
- ADDR_WIDTH, $clog2(KERN_SIZE), width of the read address.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- input_V_dout  in  COEFF_WIDTH  coefficient at the FIFO head.
- input_V_empty_n  in  1  FIFO head valid.
- input_V_read  out  1  pop strobe; a word is accepted when read=1.
- start  in  1  single-cycle request to (re)load KERN_SIZE words.
- loaded  out  1  bank holds a complete, consistent set.
- load_count  out  ADDR_WIDTH+1  words accepted in the current load.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  coefficient index.
- rd_data  out  COEFF_WIDTH  registered read data.

Behaviour:
- Reset (ap_rst=1 at a clock edge):
  - state=IDLE; wr_ptr=0; load_count=0; loaded=0; rd_data=0.
  - input_V_read=0 during any cycle where ap_rst=1.
  - Bank contents are not cleared.
- FSM has three states: IDLE, LOAD, READY.
- IDLE:
  - input_V_read=0.
  - start=1 → LOAD next cycle, with wr_ptr=0 and load_count=0.
- LOAD:
  - input_V_read = input_V_empty_n. This is combinational, asserted only in LOAD, and never when empty_n=0.
  - On each accept: mem[wr_ptr] ← dout; wr_ptr++; load_count++.
  - Accept with wr_ptr=KERN_SIZE-1 → READY next cycle; wr_ptr=0; loaded=1 from that cycle.
  - Exactly KERN_SIZE words are popped per load, never KERN_SIZE+1.
  - empty_n low → wait indefinitely; no timeout.
  - start is ignored in LOAD.
- READY:
  - input_V_read=0; loaded=1; load_count holds KERN_SIZE.
  - start=1 → LOAD next cycle. loaded falls in that same next cycle; load_count and wr_ptr clear.
- Read port (all states):
  - rd_en=1 → rd_data ← mem[rd_addr] at the next edge (1-cycle latency).
  - rd_en=0 → rd_data holds.
  - rd_addr ≥ KERN_SIZE → rd_data ← 0.
  - Reads while loaded=0 return current bank contents; the datapath must not use them.
- Simultaneous events:
  - start and rd_en in the same READY cycle: the read returns pre-reload data. The bank is not overwritten until the first accept in LOAD, at the earliest one cycle later.
  - Same-cycle write and read of the same address in LOAD: read returns the old value.
- Reset mid-LOAD: the load is abandoned and returns to IDLE. Words already popped are lost; upstream must also be reset.
- Arithmetic: wr_ptr and load_count are unsigned and never wrap past KERN_SIZE.

Optional Feature:
- Macro: WEIGHT_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output port checksum, COEFF_WIDTH+ADDR_WIDTH bits wide.
  - Holds the two's-complement signed sum of all words accepted in the current load; each coefficient is sign-extended.
  - Cleared to 0 on reset and on the IDLE/READY→LOAD transition.
  - Updates on each accept and is final when loaded rises.
- Undefined: port and accumulator absent; all other behaviour identical.

Test Plan:
- KERN_SIZE=4, start, FIFO supplies 0x0001,0x0002,0xFFFF,0x7FFF back-to-back:
  - input_V_read high exactly 4 cycles; loaded=1 the cycle after the 4th accept; load_count=4.
  - rd_addr 0..3 return 1, 2, 0xFFFF, 0x7FFF one cycle after rd_en.
- Same load with empty_n toggling 1,0,0,1,1,0,1:
  - input_V_read never high while empty_n=0; exactly 4 pops; bank contents correct.
  - A 5th word left in the FIFO is not popped.
- READY with bank {1,2,3,4}; start and rd_en(addr=2) in the same cycle; then new words 9,8,7,6:
  - First read returns 3; loaded drops next cycle.
  - After reload, addr 2 returns 7.
- ap_rst asserted after 2 of 4 accepts:
  - Next cycle: loaded=0, load_count=0, input_V_read=0, rd_data=0, state IDLE.
  - start then loads 4 fresh words correctly.
- rd_addr=5 with KERN_SIZE=4 → rd_data=0. With rd_en=0, rd_data holds its previous value.
- With WEIGHT_LOADER_CHECKSUM_EN, words 0x0001,0x0002,0xFFFF,0x7FFF (COEFF_WIDTH=16):
  - checksum = 1+2-1+32767 = 32769 when loaded rises.
  - Resets to 0 on the next start.

Source files
------------

// File: rtl/weight_stream_loader.sv
// weight_stream_loader: pops KERN_SIZE coefficients from an ap_fifo into a register bank and
// serves them through a registered read port. Optional checksum output: WEIGHT_LOADER_CHECKSUM_EN.
module weight_stream_loader #(
    parameter int unsigned COEFF_WIDTH = 16,
    parameter int unsigned KERN_SIZE   = 9,
    parameter int unsigned ADDR_WIDTH  = $clog2(KERN_SIZE)
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic [COEFF_WIDTH-1:0] input_V_dout,
    input  logic                   input_V_empty_n,
    output logic                   input_V_read,
    input  logic                   start,
    output logic                   loaded,
    output logic [ADDR_WIDTH:0]    load_count,
    input  logic                   rd_en,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic [COEFF_WIDTH-1:0] rd_data
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    ,
    output logic [COEFF_WIDTH+ADDR_WIDTH-1:0] checksum
`endif
);

    localparam int unsigned IDX_WIDTH = (KERN_SIZE > 1) ? $clog2(KERN_SIZE) : 1;
    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(KERN_SIZE - 1);
    localparam logic [CNT_WIDTH-1:0] KERN_CNT = CNT_WIDTH'(KERN_SIZE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [IDX_WIDTH-1:0]   wr_ptr;
    logic [COEFF_WIDTH-1:0] mem [KERN_SIZE];
    logic                   accept;
    logic                   last_accept;
    logic                   begin_load;
    logic                   addr_ok;

    // Next state and pop strobe; the pop is combinational so a word is never left half-taken.
    always_comb begin
        state_next   = state;
        input_V_read = 1'b0;
        begin_load   = 1'b0;
        last_accept  = 1'b0;
        case (state)
            IDLE, READY: begin
                if (start) begin
                    begin_load = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                input_V_read = input_V_empty_n & ~ap_rst;
                if (input_V_read && (wr_ptr == LAST_IDX)) begin
                    last_accept = 1'b1;
                    state_next  = READY;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept  = input_V_read;
    assign addr_ok = ({1'b0, rd_addr} < KERN_CNT);

    // Control registers and the registered read port.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            load_count <= '0;
            loaded     <= 1'b0;
            rd_data    <= '0;
        end else begin
            state <= state_next;
            if (begin_load) begin
                wr_ptr     <= '0;
                load_count <= '0;
                loaded     <= 1'b0;
            end else if (accept) begin
                load_count <= load_count + 1'b1;
                if (last_accept) begin
                    wr_ptr <= '0;
                    loaded <= 1'b1;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
            if (rd_en) begin
                rd_data <= addr_ok ? mem[IDX_WIDTH'(rd_addr)] : '0;
            end
        end
    end

    // Bank is deliberately not reset; a same-cycle read sees the previous value.
    always_ff @(posedge ap_clk) begin
        if (accept) begin
            mem[wr_ptr] <= input_V_dout;
        end
    end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    localparam int unsigned SUM_WIDTH = COEFF_WIDTH + ADDR_WIDTH;

    // Signed running sum of the words accepted in the current load.
    always_ff @(posedge ap_clk) begin
        if (ap_rst || begin_load) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + SUM_WIDTH'($signed(input_V_dout));
        end
    end
`endif

endmodule

// File: tb/tb_weight_stream_loader.sv
// Directed bench for weight_stream_loader (KERN_SIZE=4, ADDR_WIDTH=3 so out-of-range addresses exist).
module tb_weight_stream_loader;

    localparam int unsigned CW = 16;
    localparam int unsigned KS = 4;
    localparam int unsigned AW = 3;

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic [CW-1:0] input_V_dout;
    logic          input_V_empty_n;
    logic          input_V_read;
    logic          start;
    logic          loaded;
    logic [AW:0]   load_count;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] rd_data;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [CW+AW-1:0] checksum;
`endif

    weight_stream_loader #(
        .COEFF_WIDTH(CW),
        .KERN_SIZE  (KS),
        .ADDR_WIDTH (AW)
    ) dut (
        .ap_clk         (ap_clk),
        .ap_rst         (ap_rst),
        .input_V_dout   (input_V_dout),
        .input_V_empty_n(input_V_empty_n),
        .input_V_read   (input_V_read),
        .start          (start),
        .loaded         (loaded),
        .load_count     (load_count),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data)
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic          s;
        logic          g;
        logic          re;
        logic [AW-1:0] ra;
        logic          x_read;
        logic          x_loaded;
        logic [AW:0]   x_cnt;
        logic [CW-1:0] x_data;
    } vec_t;

    int            total = 0;
    int            bad = 0;
    int            reads = 0;
    logic          rd_seen;
    logic [CW-1:0] fifo_q[$];
    logic [CW-1:0] junk;
    vec_t          tbl[12];

    function automatic vec_t mk(input logic s, input logic g, input logic re, input logic [AW-1:0] ra,
                                input logic xr, input logic xl, input logic [AW:0] xc,
                                input logic [CW-1:0] xd);
        vec_t v;
        v.s = s; v.g = g; v.re = re; v.ra = ra;
        v.x_read = xr; v.x_loaded = xl; v.x_cnt = xc; v.x_data = xd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, sample the pop strobe before the edge, pop the model FIFO after it.
    task automatic do_cycle(input logic s, input logic g, input logic re, input logic [AW-1:0] ra);
        start   = s;
        rd_en   = re;
        rd_addr = ra;
        input_V_empty_n = g && (fifo_q.size() > 0);
        input_V_dout    = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        #1;
        rd_seen = input_V_read;
        if (!input_V_empty_n) check("read_while_empty", 32'(rd_seen), 32'd0);
        @(posedge ap_clk);
        #1;
        if (rd_seen) begin
            junk = fifo_q.pop_front();
            reads++;
        end
        start = 1'b0;
        rd_en = 1'b0;
        input_V_empty_n = 1'b0;
    endtask

    task automatic load_words(input logic [CW-1:0] w0, input logic [CW-1:0] w1,
                              input logic [CW-1:0] w2, input logic [CW-1:0] w3);
        fifo_q = {w0, w1, w2, w3};
        do_cycle(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic read_check(input logic [AW-1:0] a, input logic [CW-1:0] exp, input string name);
        do_cycle(1'b0, 1'b0, 1'b1, a);
        check(name, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        logic gp[7];
        ap_rst = 1'b1;
        start = 1'b0;
        rd_en = 1'b0;
        rd_addr = '0;
        input_V_empty_n = 1'b0;
        input_V_dout = '0;

        // Reset with data waiting: no pop may happen.
        fifo_q = {16'h0001, 16'h0002, 16'hFFFF, 16'h7FFF};
        do_cycle(1'b0, 1'b1, 1'b0, '0);
        check("rst_read", 32'(rd_seen), 32'd0);
        do_cycle(1'b0, 1'b1, 1'b0, '0);
        ap_rst = 1'b0;
        check("rst_loaded", 32'(loaded), 32'd0);
        check("rst_count", 32'(load_count), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_fifo_untouched", fifo_q.size(), 32'd4);

        // Back-to-back load then reads including out-of-range and hold.
        tbl[0]  = mk(1, 1, 0, 3'd0, 0, 0, 4'd0, 16'h0000);
        tbl[1]  = mk(0, 1, 0, 3'd0, 1, 0, 4'd1, 16'h0000);
        tbl[2]  = mk(0, 1, 0, 3'd0, 1, 0, 4'd2, 16'h0000);
        tbl[3]  = mk(0, 1, 0, 3'd0, 1, 0, 4'd3, 16'h0000);
        tbl[4]  = mk(0, 1, 0, 3'd0, 1, 1, 4'd4, 16'h0000);
        tbl[5]  = mk(0, 1, 1, 3'd0, 0, 1, 4'd4, 16'h0001);
        tbl[6]  = mk(0, 1, 1, 3'd1, 0, 1, 4'd4, 16'h0002);
        tbl[7]  = mk(0, 1, 1, 3'd2, 0, 1, 4'd4, 16'hFFFF);
        tbl[8]  = mk(0, 1, 1, 3'd3, 0, 1, 4'd4, 16'h7FFF);
        tbl[9]  = mk(0, 1, 0, 3'd0, 0, 1, 4'd4, 16'h7FFF);
        tbl[10] = mk(0, 1, 1, 3'd5, 0, 1, 4'd4, 16'h0000);
        tbl[11] = mk(0, 0, 0, 3'd2, 0, 1, 4'd4, 16'h0000);
        reads = 0;
        for (int i = 0; i < 12; i++) begin
            do_cycle(tbl[i].s, tbl[i].g, tbl[i].re, tbl[i].ra);
            check($sformatf("t1_read[%0d]", i), 32'(rd_seen), 32'(tbl[i].x_read));
            check($sformatf("t1_loaded[%0d]", i), 32'(loaded), 32'(tbl[i].x_loaded));
            check($sformatf("t1_count[%0d]", i), 32'(load_count), 32'(tbl[i].x_cnt));
            check($sformatf("t1_rd_data[%0d]", i), 32'(rd_data), 32'(tbl[i].x_data));
        end
        check("t1_pops", reads, 32'd4);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        check("t1_checksum", 32'(checksum), 32'd32769);
`endif

        // Gated FIFO with a spare fifth word that must stay put.
        fifo_q = {16'h0001, 16'h0002, 16'hFFFF, 16'h7FFF, 16'h5555};
        do_cycle(1'b1, 1'b0, 1'b0, '0);
        check("t2_loaded_fall", 32'(loaded), 32'd0);
        check("t2_count_clr", 32'(load_count), 32'd0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        check("t2_checksum_clr", 32'(checksum), 32'd0);
`endif
        gp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        reads = 0;
        for (int i = 0; i < 7; i++) do_cycle(1'b0, gp[i], 1'b0, '0);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b1, 1'b0, '0);
        check("t2_pops", reads, 32'd4);
        check("t2_fifo_left", fifo_q.size(), 32'd1);
        check("t2_loaded", 32'(loaded), 32'd1);
        check("t2_count", 32'(load_count), 32'd4);
        read_check(3'd0, 16'h0001, "t2_bank0");
        read_check(3'd1, 16'h0002, "t2_bank1");
        read_check(3'd2, 16'hFFFF, "t2_bank2");
        read_check(3'd3, 16'h7FFF, "t2_bank3");

        // Start and read in the same READY cycle return pre-reload data.
        load_words(16'd1, 16'd2, 16'd3, 16'd4);
        check("t3_loaded_pre", 32'(loaded), 32'd1);
        fifo_q = {16'd9, 16'd8, 16'd7, 16'd6};
        do_cycle(1'b1, 1'b1, 1'b1, 3'd2);
        check("t3_read_in_ready", 32'(rd_seen), 32'd0);
        check("t3_old_data", 32'(rd_data), 32'd3);
        check("t3_loaded_drop", 32'(loaded), 32'd0);
        check("t3_count_clr", 32'(load_count), 32'd0);
        // First accept writes addr 0 while the read of addr 0 still sees the old word.
        do_cycle(1'b0, 1'b1, 1'b1, 3'd0);
        check("t3_same_addr_old", 32'(rd_data), 32'd1);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b1, 1'b0, '0);
        check("t3_loaded", 32'(loaded), 32'd1);
        read_check(3'd2, 16'd7, "t3_new_addr2");
        read_check(3'd0, 16'd9, "t3_new_addr0");

        // Reset after two accepts abandons the load.
        fifo_q = {16'hA001, 16'hA002, 16'hA003, 16'hA004};
        do_cycle(1'b1, 1'b0, 1'b0, '0);
        do_cycle(1'b0, 1'b1, 1'b0, '0);
        do_cycle(1'b0, 1'b1, 1'b0, '0);
        check("t4_count_mid", 32'(load_count), 32'd2);
        ap_rst = 1'b1;
        do_cycle(1'b0, 1'b1, 1'b0, '0);
        check("t4_read_in_rst", 32'(rd_seen), 32'd0);
        ap_rst = 1'b0;
        check("t4_loaded", 32'(loaded), 32'd0);
        check("t4_count", 32'(load_count), 32'd0);
        check("t4_rd_data", 32'(rd_data), 32'd0);
        do_cycle(1'b0, 1'b1, 1'b0, '0);
        check("t4_idle_no_read", 32'(rd_seen), 32'd0);
        load_words(16'hB001, 16'hB002, 16'hB003, 16'hB004);
        check("t4_reload_loaded", 32'(loaded), 32'd1);
        check("t4_reload_count", 32'(load_count), 32'd4);
        read_check(3'd0, 16'hB001, "t4_bank0");
        read_check(3'd1, 16'hB002, "t4_bank1");
        read_check(3'd2, 16'hB003, "t4_bank2");
        read_check(3'd3, 16'hB004, "t4_bank3");
        read_check(3'd7, 16'h0000, "t4_oob7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
